cv32e40p_alu_fault_tracker: RTL and testbench

- Sequencing controller for the 4-ALU TMR replica set in EX.
- Consumes per-cycle voter mismatch flags from the 3 active replicas and keeps a saturating error count per ALU.
- Promotes an ALU to permanently faulty once its count reaches a threshold.
- Runs a drain handshake with the controller before it updates the permanent-fault vector that drives the faulty-ALU decoder.

---
 rtl/cv32e40p_pkg.sv | 16 +
 rtl/cv32e40p_alu_err_counter.sv | 69 ++++++
 rtl/cv32e40p_alu_fault_tracker.sv | 123 ++++++++++++
 tb/tb_cv32e40p_alu_fault_tracker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the EX-stage ALU replica fault tracker.
// Decay windowing is selected by CV32E40P_ALU_FAULT_DECAY_EN.
package cv32e40p_pkg;

    localparam int NUM_ALU_REPLICA = 4;
    localparam int FT_CNT_W        = 3;
    localparam int FT_THRESHOLD    = 4;
    localparam int FT_WINDOW_LEN   = 8;

    typedef enum logic [1:0] {
        FT_IDLE,
        FT_REQ,
        FT_SWITCH
    } fault_fsm_e;

endpackage

// File: rtl/cv32e40p_alu_err_counter.sv
// Per-ALU saturating error counter with sticky threshold flag.
// CV32E40P_ALU_FAULT_DECAY_EN adds window-based decay of the count.
module cv32e40p_alu_err_counter #(
    parameter int CNT_W           = 3,
    parameter int FAULT_THRESHOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
`ifdef CV32E40P_ALU_FAULT_DECAY_EN
    input  logic             frozen,
    input  logic             wrap,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESHOLD);

    logic [CNT_W-1:0] cnt_nxt;

`ifdef CV32E40P_ALU_FAULT_DECAY_EN
    logic hit;

    // Increment on a mismatch, otherwise decay at a clean window wrap.
    always_comb begin
        cnt_nxt = cnt;
        if (inc) begin
            if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        end else if (wrap && !frozen && !hit && cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Hit flag remembers any mismatch seen in the current window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else if (clear || wrap) begin
            hit <= 1'b0;
        end else if (inc) begin
            hit <= 1'b1;
        end
    end
`else
    // Strict accumulation: count only ever rises, saturating at max.
    always_comb begin
        cnt_nxt = cnt;
        if (inc && cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
    end
`endif

    // Counter and sticky pending flag, set on the same edge as the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            pending <= pending | (cnt_nxt >= THRESH);
        end
    end

endmodule

// File: rtl/cv32e40p_alu_fault_tracker.sv
// Tracks replica mismatches and sequences permanent-fault promotion.
// CV32E40P_ALU_FAULT_DECAY_EN enables the shared vote decay window.
module cv32e40p_alu_fault_tracker
    import cv32e40p_pkg::*;
#(
    parameter int CNT_W           = FT_CNT_W,
    parameter int FAULT_THRESHOLD = FT_THRESHOLD,
    parameter int WINDOW_LEN      = FT_WINDOW_LEN
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vote_valid_i,
    input  logic [NUM_ALU_REPLICA-1:0]     mismatch_i,
    input  logic [NUM_ALU_REPLICA-1:0]     active_alu_i,
    input  logic                           no_majority_i,
    input  logic                           clear_i,
    input  logic                           reconfig_ack_i,
    output logic                           reconfig_req_o,
    output logic [NUM_ALU_REPLICA-1:0]     permanent_faulty_alu_o,
    output logic                           uncorrectable_o,
    output logic [NUM_ALU_REPLICA*CNT_W-1:0] err_cnt_o
);

    fault_fsm_e                 state_q, state_d;
    logic [NUM_ALU_REPLICA-1:0] perm_q, perm_d;
    logic [NUM_ALU_REPLICA-1:0] pending;
    logic [NUM_ALU_REPLICA-1:0] eff;
    logic                       wrap;

    assign eff = (vote_valid_i && !no_majority_i)
               ? (mismatch_i & active_alu_i & ~perm_q)
               : '0;

    assign permanent_faulty_alu_o = perm_q;

`ifdef CV32E40P_ALU_FAULT_DECAY_EN
    localparam int WIN_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);

    logic [WIN_W-1:0] win_q;

    assign wrap = vote_valid_i && (win_q == WIN_LAST);

    // Shared window counter over valid votes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (clear_i) begin
            win_q <= '0;
        end else if (vote_valid_i) begin
            win_q <= wrap ? '0 : win_q + 1'b1;
        end
    end
`else
    assign wrap = 1'b0;
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

    for (genvar i = 0; i < NUM_ALU_REPLICA; i++) begin : g_cnt
        cv32e40p_alu_err_counter #(
            .CNT_W           (CNT_W),
            .FAULT_THRESHOLD (FAULT_THRESHOLD)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear_i),
            .inc     (eff[i]),
`ifdef CV32E40P_ALU_FAULT_DECAY_EN
            .frozen  (perm_q[i]),
            .wrap    (wrap),
`endif
            .cnt     (err_cnt_o[i*CNT_W +: CNT_W]),
            .pending (pending[i])
        );
    end

    // Drain handshake and permanent-vector update; clear wins over all.
    always_comb begin
        state_d        = state_q;
        perm_d         = perm_q;
        reconfig_req_o = 1'b0;
        unique case (state_q)
            FT_IDLE: begin
                if (|(pending & ~perm_q)) state_d = FT_REQ;
            end
            FT_REQ: begin
                reconfig_req_o = 1'b1;
                if (reconfig_ack_i) state_d = FT_SWITCH;
            end
            FT_SWITCH: begin
                perm_d  = perm_q | pending;
                state_d = FT_IDLE;
            end
            default: state_d = FT_IDLE;
        endcase
        if (clear_i) begin
            state_d = FT_IDLE;
            perm_d  = '0;
        end
    end

    // FSM state and permanent-fault vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FT_IDLE;
            perm_q  <= '0;
        end else begin
            state_q <= state_d;
            perm_q  <= perm_d;
        end
    end

    // One-cycle pulse flagging a vote with no majority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uncorrectable_o <= 1'b0;
        end else begin
            uncorrectable_o <= vote_valid_i & no_majority_i;
        end
    end

endmodule

// File: tb/tb_cv32e40p_alu_fault_tracker.sv
// Self-checking bench for cv32e40p_alu_fault_tracker.
// Directed scenarios plus randomized votes against a rule-level model.
module tb_cv32e40p_alu_fault_tracker;

    localparam int N   = 4;
    localparam int CW  = 3;
    localparam int TH  = 4;
    localparam int WL  = 8;
    localparam int MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          vote_valid_i;
    logic [N-1:0]  mismatch_i;
    logic [N-1:0]  active_alu_i;
    logic          no_majority_i;
    logic          clear_i;
    logic          reconfig_ack_i;
    logic          reconfig_req_o;
    logic [N-1:0]  permanent_faulty_alu_o;
    logic          uncorrectable_o;
    logic [N*CW-1:0] err_cnt_o;

    cv32e40p_alu_fault_tracker dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .vote_valid_i           (vote_valid_i),
        .mismatch_i             (mismatch_i),
        .active_alu_i           (active_alu_i),
        .no_majority_i          (no_majority_i),
        .clear_i                (clear_i),
        .reconfig_ack_i         (reconfig_ack_i),
        .reconfig_req_o         (reconfig_req_o),
        .permanent_faulty_alu_o (permanent_faulty_alu_o),
        .uncorrectable_o        (uncorrectable_o),
        .err_cnt_o              (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int       m_cnt [N];
    bit       m_hit [N];
    bit [N-1:0] m_pend;
    bit [N-1:0] m_perm;
    bit       m_req;
    bit       m_sw;
    bit       m_unc;
    int       m_win;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*CW-1:0] pack_cnt();
        logic [N*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_hit[i] = 0;
        end
        m_pend = '0;
        m_perm = '0;
        m_req  = 0;
        m_sw   = 0;
        m_unc  = 0;
        m_win  = 0;
    endtask

    task automatic model_step(input bit vv, input bit [N-1:0] mis,
                              input bit [N-1:0] act, input bit nm,
                              input bit clr, input bit ack);
        bit [N-1:0] eff;
        bit [N-1:0] old_pend;
        bit wrap;
        m_unc = vv & nm;
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                m_hit[i] = 0;
            end
            m_pend = '0;
            m_perm = '0;
            m_req  = 0;
            m_sw   = 0;
            m_win  = 0;
            return;
        end
        eff      = (vv && !nm) ? (mis & act & ~m_perm) : '0;
        old_pend = m_pend;
        wrap     = vv && (m_win == WL - 1);
        for (int i = 0; i < N; i++) begin
            if (eff[i]) begin
                if (m_cnt[i] < MAX) m_cnt[i]++;
            end
`ifdef CV32E40P_ALU_FAULT_DECAY_EN
            else if (wrap && !m_perm[i] && !m_hit[i] && m_cnt[i] > 0)
                m_cnt[i]--;
            m_hit[i] = wrap ? 1'b0 : (m_hit[i] | eff[i]);
`endif
            if (m_cnt[i] >= TH) m_pend[i] = 1'b1;
        end
        if (vv) m_win = (m_win + 1) % WL;
        if (m_sw) begin
            m_perm = m_perm | old_pend;
            m_sw   = 0;
        end else if (m_req) begin
            if (ack) begin
                m_req = 0;
                m_sw  = 1;
            end
        end else if ((old_pend & ~m_perm) != 0) begin
            m_req = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_req"},  32'(reconfig_req_o),         32'(m_req));
        check({tag, "_perm"}, 32'(permanent_faulty_alu_o), 32'(m_perm));
        check({tag, "_unc"},  32'(uncorrectable_o),        32'(m_unc));
        check({tag, "_cnt"},  32'(err_cnt_o),              32'(pack_cnt()));
    endtask

    task automatic step(input bit vv, input bit [N-1:0] mis,
                        input bit [N-1:0] act, input bit nm,
                        input bit clr, input bit ack, input string tag);
        vote_valid_i   = vv;
        mismatch_i     = mis;
        active_alu_i   = act;
        no_majority_i  = nm;
        clear_i        = clr;
        reconfig_ack_i = ack;
        @(posedge clk);
        model_step(vv, mis, act, nm, clr, ack);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(0, 4'b0000, 4'b0111, 0, 0, 0, tag);
    endtask

    task automatic do_clear();
        step(0, 4'b0000, 4'b0111, 0, 1, 0, "clr");
    endtask

    initial begin
        bit [N-1:0] masks [4];
        masks[0] = 4'b0111;
        masks[1] = 4'b1011;
        masks[2] = 4'b1101;
        masks[3] = 4'b1110;

        rst_n          = 1'b0;
        vote_valid_i   = 1'b0;
        mismatch_i     = '0;
        active_alu_i   = 4'b0111;
        no_majority_i  = 1'b0;
        clear_i        = 1'b0;
        reconfig_ack_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Single ALU reaching threshold, then handshake.
        for (int k = 0; k < 4; k++) step(1, 4'b0010, 4'b0111, 0, 0, 0, "t1_vote");
        check("t1_cnt1", 32'(err_cnt_o[CW +: CW]), 32'd4);
        check("t1_noreq", 32'(reconfig_req_o), 32'd0);
        idle(1, "t1_wait");
        check("t1_req", 32'(reconfig_req_o), 32'd1);
        idle(2, "t1_hold");
        step(0, 4'b0000, 4'b0111, 0, 0, 1, "t1_ack");
        check("t1_perm_pre", 32'(permanent_faulty_alu_o), 32'd0);
        idle(1, "t1_sw");
        check("t1_perm", 32'(permanent_faulty_alu_o), 32'b0010);
        idle(3, "t1_after");
        do_clear();

        // Inactive ALU mismatches are ignored.
        for (int k = 0; k < 10; k++) step(1, 4'b1000, 4'b0111, 0, 0, 0, "t2_vote");
        idle(2, "t2_idle");
        check("t2_cnt3", 32'(err_cnt_o[3*CW +: CW]), 32'd0);
        check("t2_req", 32'(reconfig_req_o), 32'd0);

        // Two ALUs reaching threshold together.
        do_clear();
        for (int k = 0; k < 4; k++) step(1, 4'b0101, 4'b0111, 0, 0, 0, "t3_vote");
        for (int k = 0; k < 4; k++) step(0, 4'b0000, 4'b0111, 0, 0, 1, "t3_ack");
        check("t3_perm", 32'(permanent_faulty_alu_o), 32'b0101);
        idle(2, "t3_idle");
        check("t3_noreq", 32'(reconfig_req_o), 32'd0);

        // No-majority vote.
        do_clear();
        step(1, 4'b0010, 4'b0111, 0, 0, 0, "t4_pre");
        step(1, 4'b0111, 4'b0111, 1, 0, 0, "t4_nm");
        check("t4_unc", 32'(uncorrectable_o), 32'd1);
        check("t4_cnt", 32'(err_cnt_o), 32'h008);
        idle(1, "t4_post");
        check("t4_unc_off", 32'(uncorrectable_o), 32'd0);

        // Clear together with ack while requesting.
        do_clear();
        for (int k = 0; k < 4; k++) step(1, 4'b0001, 4'b0111, 0, 0, 0, "t5_vote");
        idle(2, "t5_wait");
        check("t5_req", 32'(reconfig_req_o), 32'd1);
        step(0, 4'b0000, 4'b0111, 0, 1, 1, "t5_clrack");
        idle(2, "t5_post");
        check("t5_perm", 32'(permanent_faulty_alu_o), 32'd0);
        check("t5_cnt", 32'(err_cnt_o), 32'd0);
        check("t5_noreq", 32'(reconfig_req_o), 32'd0);

        // Asynchronous reset mid-request.
        for (int k = 0; k < 4; k++) step(1, 4'b0100, 4'b0111, 0, 0, 0, "t6_vote");
        idle(2, "t6_wait");
        check("t6_req", 32'(reconfig_req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(reconfig_req_o), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all("t6_rst");
        rst_n = 1'b1;

        // Saturation.
        for (int k = 0; k < 12; k++) step(1, 4'b0001, 4'b0111, 0, 0, 0, "t7_sat");
        check("t7_cnt0", 32'(err_cnt_o[0 +: CW]), 32'(MAX));
        do_clear();

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            bit vv, nm, clr, ack;
            bit [N-1:0] mis, act;
            vv  = ($urandom_range(0, 3) != 0);
            nm  = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 199) == 0);
            ack = $urandom_range(0, 1);
            mis = N'($urandom & $urandom);
            act = masks[$urandom_range(0, 3)];
            step(vv, mis, act, nm, clr, ack, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
